// File: rtl/attn_v_reshape_scheduler_if.sv
// attn_v_reshape_scheduler_if: head-side and reshaper-side bus of the ATTN@V scheduler
// Signals: i_head_spikes/i_head_valid per-head beats in, o_head_ready one-hot grant,
//   o_spikes_out_ext/o_spikes_valid beat stream to the reshaper, o_grp_tag/o_grp_tag_valid group tag.
// slave = scheduler side, master = producer/reshaper side.
interface attn_v_reshape_scheduler_if #(
  parameter int TIME_STEPS = 4,
  parameter int NUM_HEADS  = 4
);
  localparam int BW = TIME_STEPS * 2;
  localparam int TW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
  logic [NUM_HEADS*BW-1:0] i_head_spikes;
  logic [NUM_HEADS-1:0]    i_head_valid;
  logic [NUM_HEADS-1:0]    o_head_ready;
  logic [BW-1:0]           o_spikes_out_ext;
  logic                    o_spikes_valid;
  logic [TW-1:0]           o_grp_tag;
  logic                    o_grp_tag_valid;
  modport slave (
    input  i_head_spikes, i_head_valid,
    output o_head_ready, o_spikes_out_ext, o_spikes_valid, o_grp_tag, o_grp_tag_valid
  );
  modport master (
    output i_head_spikes, i_head_valid,
    input  o_head_ready, o_spikes_out_ext, o_spikes_valid, o_grp_tag, o_grp_tag_valid
  );
endinterface

// File: rtl/attn_v_reshape_scheduler.sv
// attn_v_reshape_scheduler: round-robin group scheduler for the shared ATTN@V LIF-to-reshape path
// Ports: s_clk clock; s_rst_n async active-low reset; i_start/i_groups_per_head run control;
//   bus (slave) per-head beats in, one-hot ready out, beat stream and group tag to the reshaper;
//   o_busy run in progress; o_done one-cycle run-end pulse.
module attn_v_reshape_scheduler #(
  parameter int TIME_STEPS        = 4,
  parameter int PATCH_EMBED_WIDTH = 32,
  parameter int NUM_HEADS         = 4,
  parameter int GRP_CNT_W         = 8
) (
  input  logic                 s_clk,
  input  logic                 s_rst_n,
  input  logic                 i_start,
  input  logic [GRP_CNT_W-1:0] i_groups_per_head,
  attn_v_reshape_scheduler_if.slave bus,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int BW    = TIME_STEPS * 2;
  localparam int BEATS = PATCH_EMBED_WIDTH / TIME_STEPS;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int HW    = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
  typedef enum logic [1:0] {IDLE, ARB, BURST, FIN} state_t;
  state_t               state_q, state_d;
  logic [HW-1:0]        grant_q, grant_d, rr_q, rr_d, win;
  logic [CW-1:0]        beat_q, beat_d;
  logic [GRP_CNT_W-1:0] rem_q [NUM_HEADS];
  logic [GRP_CNT_W-1:0] rem_d [NUM_HEADS];
  logic [BW-1:0]        data_q, data_d;
  logic                 sv_q, sv_d;
  logic                 t1v_q, t1v_d, tv_q, tv_d;
  logic [HW-1:0]        t1_q, t1_d, tag_q, tag_d;
  logic [NUM_HEADS-1:0] elig;
  logic                 found, xfer, last, rest_zero;
  assign xfer = (state_q == BURST) && bus.i_head_valid[grant_q];
  assign last = xfer && (beat_q == CW'(BEATS - 1));
  assign bus.o_head_ready     = (state_q == BURST) ? NUM_HEADS'(1) << grant_q : '0;
  assign bus.o_spikes_out_ext = data_q;
  assign bus.o_spikes_valid   = sv_q;
  assign bus.o_grp_tag        = tag_q;
  assign bus.o_grp_tag_valid  = tv_q;
  assign o_busy = (state_q != IDLE);
  // done waits until the final group's tag has left the 2-stage delay
  assign o_done = (state_q == FIN) && !t1v_q && !tv_q;
  always_comb begin
    for (int h = 0; h < NUM_HEADS; h++) elig[h] = bus.i_head_valid[h] && (rem_q[h] != '0);
  end
  // descending scan so the smallest offset from the RR pointer is the last (winning) write
  always_comb begin
    found = 1'b0;
    win   = rr_q;
    for (int i = NUM_HEADS - 1; i >= 0; i--)
      if (elig[(int'(rr_q) + i) % NUM_HEADS]) begin
        found = 1'b1;
        win   = HW'((int'(rr_q) + i) % NUM_HEADS);
      end
  end
  // true when the group finishing now is the last one owed by any head
  always_comb begin
    rest_zero = (rem_q[grant_q] == GRP_CNT_W'(1));
    for (int h = 0; h < NUM_HEADS; h++)
      if (HW'(h) != grant_q && rem_q[h] != '0) rest_zero = 1'b0;
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    rem_d   = rem_q;
    data_d  = xfer ? bus.i_head_spikes[grant_q*BW +: BW] : data_q;
    sv_d    = xfer;
    t1v_d   = last;
    t1_d    = last ? grant_q : t1_q;
    tv_d    = t1v_q;
    tag_d   = t1v_q ? t1_q : tag_q;
    case (state_q)
      IDLE: if (i_start) begin
        for (int h = 0; h < NUM_HEADS; h++) rem_d[h] = i_groups_per_head;
        state_d = (i_groups_per_head == '0) ? FIN : ARB;
      end
      ARB: if (found) begin
        grant_d = win;
        beat_d  = '0;
        state_d = BURST;
      end
      BURST: if (xfer) begin
        beat_d = last ? '0 : beat_q + 1'b1;
        if (last) begin
          rem_d[grant_q] = rem_q[grant_q] - 1'b1;
          rr_d    = (grant_q == HW'(NUM_HEADS - 1)) ? '0 : grant_q + 1'b1;
          state_d = rest_zero ? FIN : ARB;
        end
      end
      FIN: if (o_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      data_q  <= '0;
      sv_q    <= 1'b0;
      t1v_q   <= 1'b0;
      t1_q    <= '0;
      tv_q    <= 1'b0;
      tag_q   <= '0;
      for (int h = 0; h < NUM_HEADS; h++) rem_q[h] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      sv_q    <= sv_d;
      t1v_q   <= t1v_d;
      t1_q    <= t1_d;
      tv_q    <= tv_d;
      tag_q   <= tag_d;
      rem_q   <= rem_d;
    end
  end
endmodule

// File: doc/attn_v_reshape_scheduler.md
Name: attn_v_reshape_scheduler

Overview:
- Sequences the shared ATTN@V LIF-to-reshape path between NUM_HEADS per-head spike producers.
- Grants one head at a time and forwards exactly BEATS_PER_GRP contiguous beats per grant, so the downstream 8-beat reshaper never mixes heads within a group.
- Tags every reshaped group with its source head.
- Counts groups per head for a configured run and signals run completion.

Parameters:
TIME_STEPS, 4, spike time steps; each beat is TIME_STEPS*2 bits.
PATCH_EMBED_WIDTH, 32, embed width; BEATS_PER_GRP = PATCH_EMBED_WIDTH/TIME_STEPS (8).
NUM_HEADS, 4, number of requesting heads (>=2).
GRP_CNT_W, 8, width of the per-head group count.

Ports:
s_clk  in  1  clock, rising edge.
s_rst_n  in  1  asynchronous, active-low reset.
i_start  in  1  one-cycle run start; ignored while o_busy=1.
i_groups_per_head  in  GRP_CNT_W  groups each head must deliver; sampled on an accepted i_start.
i_head_spikes  in  NUM_HEADS*TIME_STEPS*2  beat data; head h occupies slice h.
i_head_valid  in  NUM_HEADS  per-head beat valid.
o_head_ready  out  NUM_HEADS  per-head ready; at most one bit high.
o_spikes_out_ext  out  TIME_STEPS*2  beat to the reshaper.
o_spikes_valid  out  1  beat valid to the reshaper; the reshaper has no backpressure.
o_grp_tag  out  clog2(NUM_HEADS)  head id of the group currently emerging from the reshaper.
o_grp_tag_valid  out  1  one-cycle pulse aligned with the reshaper output valid.
o_busy  out  1  run in progress.
o_done  out  1  one-cycle pulse at run end.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, RR pointer=0, all counters 0.
- Reset mid-run abandons the run and emits no o_done.
- The integrator must reset the reshaper together with this block so its beat counter starts at 0.
- FSM states: IDLE, ARB, BURST, FIN.
- IDLE, on i_start:
  - load remaining[h]=i_groups_per_head for every h; o_busy=1.
  - If i_groups_per_head=0, go to FIN; otherwise go to ARB.
- ARB: eligible[h] = i_head_valid[h] && remaining[h]!=0.
  - Round-robin: search starts at the RR pointer, lowest index wins from there.
  - On a win: latch grant id, clear the beat counter, go to BURST.
  - With no eligible head, stay in ARB. No ready is asserted in ARB.
- BURST:
  - o_head_ready[grant]=1 (combinational from state and grant); all other ready bits 0.
  - A beat transfers when valid && ready.
  - Each transfer registers data to o_spikes_out_ext and asserts o_spikes_valid the next cycle (1-cycle latency).
  - o_spikes_valid=0 in any cycle without a transfer. Data holds its last value when invalid.
  - If the granted head drops valid, the burst stalls with grant held. A burst is never preempted or switched mid-group.
- Final beat (beat counter = BEATS_PER_GRP-1 and transfer):
  - decrement remaining[grant]; RR pointer = grant+1 mod NUM_HEADS.
  - Ready drops the next cycle.
  - If every remaining count is now 0, go to FIN; otherwise go to ARB.
- Tagging: a final beat accepted in cycle T gives o_spikes_valid at T+1 and reshaper output valid at T+2.
  - o_grp_tag_valid pulses at T+2 with o_grp_tag = that grant id.
  - o_grp_tag holds its value until the next pulse. It is carried through a 2-stage delay so back-to-back groups tag correctly.
- FIN:
  - o_done pulses 1 cycle, timed after the last o_grp_tag_valid (or the cycle after i_start when the count is 0).
  - Then o_busy=0 and go to IDLE.
- Simultaneous events:
  - i_start during a run is ignored.
  - Valid from an ungranted head is held off by ready=0. Its data must stay stable until granted (producer's duty).
- Width rules:
  - beat counter width clog2(BEATS_PER_GRP), wraps to 0 after the final beat.
  - remaining[h] never underflows; a head with remaining=0 is never eligible.
- Minimum spacing: at least 1 idle ARB cycle between consecutive bursts, so each group takes at least BEATS_PER_GRP+1 cycles.

Test Plan:
- Single head valid, groups_per_head=1, NUM_HEADS=4, head 0 always valid → 8 consecutive o_spikes_valid beats, tag=0 pulse 2 cycles after beat 8 at the scheduler input. Heads 1-3 never become eligible, so the run stays busy with no o_done (checks the done condition).
- All 4 heads valid, groups_per_head=2 → grant order 0,1,2,3,0,1,2,3; 8 tag pulses 0,1,2,3,0,1,2,3; o_done once after the last tag; o_busy then 0.
- Head 2 drops valid at beat 4 for 5 cycles while heads 0, 1 and 3 are valid → grant stays 2, no other ready rises, the group resumes and still totals 8 beats, tag=2.
- i_start with groups_per_head=0 → o_done the next cycle, no ready, no o_spikes_valid.
- Second i_start mid-run → ignored; counts unchanged and the group total still equals 4*N.
- s_rst_n asserted at beat 5 of a burst → all outputs 0 immediately, FSM=IDLE. A new run after release starts clean at grant 0 with correct tags.
